// File: rtl/uart_rx_buffered.sv
// UART receiver with a configurable frame format, sticky error flags, a
// first-word-fall-through receive FIFO and line-idle detection.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_BITS    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          err_clr,
  output logic                          rx_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 sync1, rs, rs_prev;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bad;
  logic                 push;
  logic [DATA_BITS-1:0] push_data;
  logic                 frame_set, parity_set;
  logic                 par_exp;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 pop, accept;
  logic [IDLE_W-1:0]    idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      sync1   <= uart_rx;
      rs      <= sync1;
      rs_prev <= rs;
    end
  end

  always_comb begin
    par_exp = (PARITY == 2) ? ~^shreg : ^shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      bad        <= 1'b0;
      push       <= 1'b0;
      push_data  <= '0;
      frame_set  <= 1'b0;
      parity_set <= 1'b0;
    end else begin
      push       <= 1'b0;
      frame_set  <= 1'b0;
      parity_set <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rs_prev && !rs) begin
            state <= S_START;
            cnt   <= HALF_BIT;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rs) begin
            state <= S_IDLE;
          end else begin
            state   <= S_DATA;
            cnt     <= FULL_BIT;
            bit_idx <= '0;
            bad     <= 1'b0;
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rs, shreg[DATA_BITS-1:1]};
            cnt   <= FULL_BIT;
            if (bit_idx == LAST_BIT) begin
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= FULL_BIT;
            state <= S_STOP;
            if (rs != par_exp) begin
              parity_set <= 1'b1;
              bad        <= 1'b1;
            end
          end
        end
        S_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= FULL_BIT;
            if (!rs) frame_set <= 1'b1;
            if (stop_idx == LAST_STOP) begin
              if (bad || !rs) begin
                state <= S_WAIT_HIGH;
              end else begin
                state     <= S_IDLE;
                push      <= 1'b1;
                push_data <= shreg;
              end
            end else begin
              stop_idx <= 1'b1;
              bad      <= bad | ~rs;
            end
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) yields one error, then waits for recovery.
          if (rs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_valid = (fifo_count != '0);
    rx_data  = rx_valid ? mem[rd_ptr] : '0;
    pop      = rx_valid & rx_ready;
    accept   = push & ((fifo_count != DEPTH) | pop);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= frame_set | (frame_err & ~err_clr);
      parity_err <= parity_set | (parity_err & ~err_clr);
      overflow   <= (push & ~accept) | (overflow & ~err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      rx_idle  <= 1'b0;
    end else if (state != S_IDLE || !rs) begin
      idle_cnt <= '0;
      rx_idle  <= 1'b0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
      rx_idle  <= (idle_cnt == IDLE_MAX - 1'b1);
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: 8N1 instance plus an 8E1 instance
// for parity handling.
module tb_uart_rx_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       line = 1'b1, line_p = 1'b1;
  logic       rx_ready = 1'b0, rx_ready_p = 1'b0;
  logic       err_clr = 1'b0, err_clr_p = 1'b0;

  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, rx_valid_p;
  logic [4:0] fifo_count, fifo_count_p;
  logic       frame_err, parity_err, overflow, rx_idle;
  logic       frame_err_p, parity_err_p, overflow_p, rx_idle_p;

  uart_rx_buffered #(
    .CLKS_PER_BIT(32), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(16), .IDLE_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .parity_err(parity_err),
    .overflow(overflow), .err_clr(err_clr), .rx_idle(rx_idle)
  );

  uart_rx_buffered #(
    .CLKS_PER_BIT(32), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
    .FIFO_DEPTH(16), .IDLE_BITS(16)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .uart_rx(line_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .fifo_count(fifo_count_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overflow(overflow_p), .err_clr(err_clr_p), .rx_idle(rx_idle_p)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] got_q[$];
  logic [7:0] mq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Words handed to the consumer, captured mid-cycle before the popping edge.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic drive_bit(input bit p, input logic v);
    if (p) line_p = v; else line = v;
    repeat (32) @(negedge clk);
  endtask

  task automatic send_frame(input bit p, input logic [7:0] d, input logic stop,
                            input bit has_par, input logic par);
    drive_bit(p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
    if (has_par) drive_bit(p, par);
    drive_bit(p, stop);
    if (p) line_p = 1'b1; else line = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
    @(negedge clk);
  endtask

  task automatic pop_one();
    set_ready(1'b1);
    set_ready(1'b0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    set_ready(1'b1);
    for (int i = 0; i < 200 && rx_valid; i++) @(negedge clk);
    set_ready(1'b0);
    check({name, "_drained"}, rx_valid, 0);
  endtask

  task automatic compare_q(input string name);
    check({name, "_len"}, got_q.size(), mq.size());
    for (int i = 0; i < mq.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", name, i), got_q[i], mq[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    bit   found;
    bit   ovf_exp, bad_any, done;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_flags", {frame_err, parity_err, overflow}, 0);
    check("reset_rx_idle", rx_idle, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // First-word latency measured from the start edge.
    lat = 0;
    found = 0;
    fork
      send_frame(0, 8'h48, 1'b1, 0, 1'b0);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          @(negedge clk);
          lat++;
          if (rx_valid) found = 1;
        end
      end
    join
    check("h_seen", found, 1);
    check("h_latency_window", (lat >= 306 && lat <= 308), 1);
    check("h_data", rx_data, 8'h48);
    check("h_flags", {frame_err, parity_err, overflow}, 0);
    pop_one();
    check("h_popped", fifo_count, 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(0, vecs[v].data, vecs[v].stop, 0, 1'b0);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_count", v), fifo_count, vecs[v].exp_push ? 1 : 0);
      check($sformatf("vec%0d_frame_err", v), frame_err, vecs[v].exp_ferr);
      if (vecs[v].exp_push) check($sformatf("vec%0d_data", v), rx_data, vecs[v].data);
      pulse_clr();
      check($sformatf("vec%0d_clr", v), frame_err, 0);
      if (vecs[v].exp_push) pop_one();
    end

    line = 1'b0;
    repeat (10) @(negedge clk);
    line = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_count", fifo_count, 0);
    check("glitch_flags", {frame_err, parity_err, overflow}, 0);

    send_frame(0, 8'h33, 1'b1, 0, 1'b0);
    check("idle_after_frame", rx_idle, 0);
    repeat (470) @(negedge clk);
    check("idle_not_yet", rx_idle, 0);
    repeat (50) @(negedge clk);
    check("idle_asserted", rx_idle, 1);
    pop_one();

    // Overflow: 17 frames into a 16-entry FIFO with nobody popping.
    mq.delete();
    ovf_exp = 0;
    for (int i = 0; i <= 16; i++) begin
      send_frame(0, 8'(i), 1'b1, 0, 1'b0);
      if (mq.size() < 16) mq.push_back(8'(i)); else ovf_exp = 1;
    end
    repeat (4) @(negedge clk);
    check("ovf_count", fifo_count, mq.size());
    check("ovf_flag", overflow, ovf_exp);
    got_q.delete();
    drain("ovf");
    compare_q("ovf_order");
    pulse_clr();
    check("ovf_clr", overflow, 0);

    // Full FIFO with the push landing on the same edge as a pop.
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      send_frame(0, 8'(8'h20 + i), 1'b1, 0, 1'b0);
      mq.push_back(8'(8'h20 + i));
    end
    repeat (4) @(negedge clk);
    check("full_count", fifo_count, 16);
    got_q.delete();
    fork
      send_frame(0, 8'h30, 1'b1, 0, 1'b0);
      begin
        repeat (307) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    mq.push_back(8'h30);
    repeat (4) @(negedge clk);
    check("coinc_count", fifo_count, 16);
    check("coinc_overflow", overflow, 0);
    drain("coinc");
    compare_q("coinc_order");

    // Reset in the middle of a frame with a word already buffered.
    send_frame(0, 8'h11, 1'b1, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_count", fifo_count, 1);
    begin
      logic [7:0] a5;
      a5 = 8'hA5;
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, a5[i]);
      line = a5[4];
      repeat (16) @(negedge clk);
    end
    rst_n = 1'b0;
    line = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_count", fifo_count, 0);
    check("midreset_valid", rx_valid, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("postreset_idle", rx_idle, 0);
    send_frame(0, 8'h3C, 1'b1, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("postreset_count", fifo_count, 1);
    check("postreset_data", rx_data, 8'h3C);
    check("postreset_ferr", frame_err, 0);
    pop_one();

    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    send_frame(1, 8'h07, 1'b1, 1, 1'b0);
    repeat (4) @(negedge clk);
    check("par_bad_flag", parity_err_p, 1);
    check("par_bad_count", fifo_count_p, 0);
    check("par_bad_ferr", frame_err_p, 0);
    err_clr_p = 1'b1;
    @(negedge clk);
    err_clr_p = 1'b0;
    @(negedge clk);
    check("par_clr", parity_err_p, 0);
    send_frame(1, 8'h07, 1'b1, 1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_good_count", fifo_count_p, 1);
    check("par_good_data", rx_data_p, 8'h07);
    check("par_good_flag", parity_err_p, 0);

    // Random frames with random consumer stalls against a word-level model.
    pulse_clr();
    got_q.delete();
    mq.delete();
    bad_any = 0;
    done = 0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [7:0] d;
          logic ok;
          d = 8'($urandom);
          ok = ($urandom_range(0, 4) != 0);
          send_frame(0, d, ok, 0, 1'b0);
          if (ok) mq.push_back(d); else bad_any = 1;
          repeat ($urandom_range(4, 40)) @(negedge clk);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rx_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    drain("rand");
    compare_q("rand_order");
    check("rand_frame_err", frame_err, bad_any);
    check("rand_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
